riscv_dmem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core: the target end of the core's load/store request interface. It accepts one request at a time over a valid/ready handshake, performs a byte-masked write or a word read on an internal word array, and returns a response after a programmable number of wait states. The bench and future bus variants use it to model a slow data memory that stalls the pipeline.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/riscv_dmem_array.sv | 32 +++
 rtl/riscv_dmem_responder.sv | 108 ++++++++++
 tb/tb_riscv_dmem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the RISC-V data-memory responder and its word array.
package riscv_mem_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // A byte address is in range when every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/riscv_dmem_array.sv
// Word array with per-byte write enables, synchronous write and combinational read.
// Contents are never reset; each byte lane is its own storage array.
module riscv_dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clock) begin
                if (we_i && wstrb_i[gi]) begin
                    lane_mem[addr_i] <= wdata_i[8*gi +: 8];
                end
            end

            assign rdata_o[8*gi +: 8] = lane_mem[addr_i];
        end
    endgenerate

endmodule

// File: rtl/riscv_dmem_responder.sv
// Target end of the core's load/store interface: one outstanding request, byte-masked
// stores, word loads, and a response delayed by WAIT_CYCLES wait states.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = addr_in_range(req_addr, ADDR_WIDTH);

    riscv_dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .we_i    (mem_we),
        .addr_i  (req_addr[ADDR_WIDTH+1:2]),
        .wstrb_i (req_wstrb),
        .wdata_i (req_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Store commits and load data is captured on this same edge.
                    mem_we  = req_write && in_range;
                    rdata_d = (!req_write && in_range) ? mem_rdata : '0;
                    err_d   = !in_range;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: unit 0 has WAIT_CYCLES=2, unit 1 has 0, unit 2 has 15.
module tb_riscv_dmem_responder;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]       req_valid, req_write, rsp_ready;
    logic [2:0][31:0] req_addr, req_wdata;
    logic [2:0][3:0]  req_wstrb;
    wire  [2:0]       req_ready, rsp_valid, rsp_err;
    wire  [2:0][31:0] rsp_rdata;

    int total = 0;
    int bad = 0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            riscv_dmem_responder #(
                .ADDR_WIDTH  (10),
                .WAIT_CYCLES ((gi == 0) ? 2 : ((gi == 1) ? 0 : 15))
            ) u_dut (
                .clock     (clock),
                .reset_n   (reset_n),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_write (req_write[gi]),
                .req_addr  (req_addr[gi]),
                .req_wdata (req_wdata[gi]),
                .req_wstrb (req_wstrb[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_ready (rsp_ready[gi]),
                .rsp_rdata (rsp_rdata[gi]),
                .rsp_err   (rsp_err[gi])
            );
        end
    endgenerate

    typedef struct {
        int          u;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   txn_no = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic txn(input vec_t v);
        int lat;
        chk("ready_idle", 32'(req_ready[v.u]), 32'd1);
        req_valid[v.u] = 1'b1;
        req_write[v.u] = v.wr;
        req_addr[v.u]  = v.addr;
        req_wdata[v.u] = v.wdata;
        req_wstrb[v.u] = v.strb;
        step();
        req_valid[v.u] = 1'b0;
        chk("ready_busy", 32'(req_ready[v.u]), 32'd0);
        lat = 1;
        while (!rsp_valid[v.u] && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("rdata", rsp_rdata[v.u], v.exp_rdata);
        chk("err", 32'(rsp_err[v.u]), 32'(v.exp_err));
        $display("txn %0d unit=%0d %s addr=%08h rdata=%08h err=%0b lat=%0d",
                 txn_no, v.u, v.wr ? "store" : "load", v.addr, rsp_rdata[v.u], rsp_err[v.u], lat);
        for (int i = 0; i < v.hold; i++) begin
            step();
            chk("hold_valid", 32'(rsp_valid[v.u]), 32'd1);
            chk("hold_rdata", rsp_rdata[v.u], v.exp_rdata);
            chk("hold_err", 32'(rsp_err[v.u]), 32'(v.exp_err));
            chk("hold_ready", 32'(req_ready[v.u]), 32'd0);
        end
        rsp_ready[v.u] = 1'b1;
        step();
        rsp_ready[v.u] = 1'b0;
        chk("ready_after", 32'(req_ready[v.u]), 32'd1);
        chk("valid_after", 32'(rsp_valid[v.u]), 32'd0);
        txn_no++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_write = '0;
        rsp_ready = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;

        repeat (2) step();
        for (int u = 0; u < 3; u++) begin
            chk("rst_ready", 32'(req_ready[u]), 32'd1);
            chk("rst_valid", 32'(rsp_valid[u]), 32'd0);
            chk("rst_rdata", rsp_rdata[u], 32'd0);
            chk("rst_err", 32'(rsp_err[u]), 32'd0);
        end
        reset_n = 1'b1;
        step();

        //                u  wr    addr           wdata          strb   hold  exp_rdata     err   lat
        vecs.push_back('{0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF,  0, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0,  0, 32'hDEAD_BEEF, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5,  0, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0,  0, 32'hDE22_BE44, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF,  0, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF,  0, 32'h0000_0000, 1'b1, 3});
        vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0,  0, 32'hCAFE_F00D, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'h0,  0, 32'h0000_0000, 1'b1, 3});
        vecs.push_back('{0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0,  0, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h0000_0043, 32'h0000_0000, 4'h0,  5, 32'hDE22_BE44, 1'b0, 3});
        vecs.push_back('{0, 1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF,  0, 32'h0000_0000, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'h0,  0, 32'hA5A5_A5A5, 1'b0, 3});
        vecs.push_back('{0, 1'b0, 32'h8000_1040, 32'h0000_0000, 4'h0,  0, 32'h0000_0000, 1'b1, 3});
        vecs.push_back('{1, 1'b1, 32'h0000_0008, 32'h0102_0304, 4'hF,  0, 32'h0000_0000, 1'b0, 1});
        vecs.push_back('{1, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0,  2, 32'h0102_0304, 1'b0, 1});
        vecs.push_back('{2, 1'b1, 32'h0000_0008, 32'h0BAD_C0DE, 4'hF,  0, 32'h0000_0000, 1'b0, 16});
        vecs.push_back('{2, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0,  0, 32'h0BAD_C0DE, 1'b0, 16});

        foreach (vecs[i]) txn(vecs[i]);

        // Reset while unit 0 sits in WAIT: the accepted store survives, its response is dropped.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0080;
        req_wdata[0] = 32'h1234_5678;
        req_wstrb[0] = 4'hF;
        step();
        req_valid[0] = 1'b0;
        step();
        chk("pre_rst_ready", 32'(req_ready[0]), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("midrst_ready", 32'(req_ready[0]), 32'd1);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst_valid", 32'(rsp_valid[0]), 32'd0);
            chk("postrst_ready", 32'(req_ready[0]), 32'd1);
        end
        txn('{0, 1'b0, 32'h0000_0080, 32'h0000_0000, 4'h0, 0, 32'h1234_5678, 1'b0, 3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
